// File: rtl/riscv_pipe_front_regs.sv
// PC, IF/ID and ID/EX pipeline registers plus EX-stage operand forwarding for a 5-stage RV32I core.
// Define PIPE_PERF_CNT_EN to add the stall/flush performance counters (o_stall_cnt, o_flush_cnt).
module riscv_pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall_f,
  input  logic              i_stall_d,
  input  logic              i_flush_d,
  input  logic              i_flush_e,
  input  logic [1:0]        i_forward_ae,
  input  logic [1:0]        i_forward_be,
  input  logic              i_pc_src,
  input  logic [31:0]       i_pc_target_e,
  input  logic [31:0]       i_instr_f,
  input  logic [31:0]       i_rs1_data_d,
  input  logic [31:0]       i_rs2_data_d,
  input  logic [31:0]       i_imm_d,
  input  logic [CTRL_W-1:0] i_ctrl_d,
  input  logic [31:0]       i_alu_result_m,
  input  logic [31:0]       i_result_w,
  output logic [31:0]       o_pc_f,
  output logic [31:0]       o_instr_d,
  output logic [31:0]       o_pc_d,
  output logic [4:0]        o_rs1_addr_d,
  output logic [4:0]        o_rs2_addr_d,
  output logic [4:0]        o_rs1_addr_e,
  output logic [4:0]        o_rs2_addr_e,
  output logic [4:0]        o_rd_addr_e,
  output logic [31:0]       o_pc_e,
  output logic [31:0]       o_pc_plus4_e,
  output logic [31:0]       o_imm_e,
  output logic [CTRL_W-1:0] o_ctrl_e,
  output logic [31:0]       o_src_a_e,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt,
`endif
  output logic [31:0]       o_write_data_e
);

  typedef struct packed {
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [31:0]       rs1_data;
    logic [31:0]       rs2_data;
    logic [31:0]       imm;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pcd_q, pcd_d;
  idex_t       idex_q, idex_d;

  // NOTE: every combinational output is given a default first so no path can infer a latch.
  always_comb begin
    pc_d      = pc_q + 32'd4;
    instr_d_d = i_instr_f;
    pcd_d     = pc_q;
    idex_d    = '0;

    // A redirect beats a fetch stall: the stalled PC is on the wrong path anyway.
    if (i_pc_src)       pc_d = i_pc_target_e;
    else if (i_stall_f) pc_d = pc_q;

    if (i_flush_d) begin
      instr_d_d = NOP_INSTR;
      pcd_d     = 32'd0;
    end else if (i_stall_d) begin
      instr_d_d = instr_d_q;
      pcd_d     = pcd_q;
    end

    if (!i_flush_e) begin
      idex_d.rs1_addr = instr_d_q[19:15];
      idex_d.rs2_addr = instr_d_q[24:20];
      idex_d.rd_addr  = instr_d_q[11:7];
      idex_d.rs1_data = i_rs1_data_d;
      idex_d.rs2_data = i_rs2_data_d;
      idex_d.imm      = i_imm_d;
      idex_d.ctrl     = i_ctrl_d;
      idex_d.pc       = pcd_q;
      idex_d.pc_plus4 = pcd_q + 32'd4;
    end
  end

  // NOTE: state registers use non-blocking assignments so all stages sample pre-edge values together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q      <= RESET_PC;
      instr_d_q <= NOP_INSTR;
      pcd_q     <= 32'd0;
      idex_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_d_q <= instr_d_d;
      pcd_q     <= pcd_d;
      idex_q    <= idex_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_stall_d && !i_flush_d)  stall_cnt_d = stall_cnt_q + 32'd1;
    if (i_flush_d || i_flush_e)   flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;
`endif

  // Code 2'b11 is reserved and falls back to the registered operand.
  always_comb begin
    case (i_forward_ae)
      2'b01:   o_src_a_e = i_result_w;
      2'b10:   o_src_a_e = i_alu_result_m;
      default: o_src_a_e = idex_q.rs1_data;
    endcase
    case (i_forward_be)
      2'b01:   o_write_data_e = i_result_w;
      2'b10:   o_write_data_e = i_alu_result_m;
      default: o_write_data_e = idex_q.rs2_data;
    endcase
  end

  assign o_pc_f       = pc_q;
  assign o_instr_d    = instr_d_q;
  assign o_pc_d       = pcd_q;
  assign o_rs1_addr_d = instr_d_q[19:15];
  assign o_rs2_addr_d = instr_d_q[24:20];
  assign o_rs1_addr_e = idex_q.rs1_addr;
  assign o_rs2_addr_e = idex_q.rs2_addr;
  assign o_rd_addr_e  = idex_q.rd_addr;
  assign o_pc_e       = idex_q.pc;
  assign o_pc_plus4_e = idex_q.pc_plus4;
  assign o_imm_e      = idex_q.imm;
  assign o_ctrl_e     = idex_q.ctrl;

endmodule

// File: tb/tb_riscv_pipe_front_regs.sv
// Directed bench for riscv_pipe_front_regs: reset, straight-line flow, load-use stall,
// branch redirect, forwarding, PC wrap and (with PIPE_PERF_CNT_EN) the performance counters.
module tb_riscv_pipe_front_regs;

  localparam logic [31:0] INSTR_A = 32'h0073_02B3; // add x5,x6,x7
  localparam logic [31:0] INSTR_B = 32'h40A4_8433; // sub x8,x9,x10
  localparam logic [31:0] INSTR_C = 32'h00C0_0513; // addi x10,x0,12
  localparam logic [31:0] INSTR_X = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_f, stall_d, flush_d, flush_e;
  logic [1:0]  forward_ae, forward_be;
  logic        pc_src;
  logic [31:0] pc_target_e, instr_f, rs1_data_d, rs2_data_d, imm_d;
  logic [15:0] ctrl_d;
  logic [31:0] alu_result_m, result_w;
  logic [31:0] pc_f, instr_d, pc_d, pc_e, pc_plus4_e, imm_e, src_a_e, write_data_e;
  logic [4:0]  rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e, rd_addr_e;
  logic [15:0] ctrl_e;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  riscv_pipe_front_regs #(
    .RESET_PC (32'h0000_0100),
    .CTRL_W   (16),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_stall_f     (stall_f),
    .i_stall_d     (stall_d),
    .i_flush_d     (flush_d),
    .i_flush_e     (flush_e),
    .i_forward_ae  (forward_ae),
    .i_forward_be  (forward_be),
    .i_pc_src      (pc_src),
    .i_pc_target_e (pc_target_e),
    .i_instr_f     (instr_f),
    .i_rs1_data_d  (rs1_data_d),
    .i_rs2_data_d  (rs2_data_d),
    .i_imm_d       (imm_d),
    .i_ctrl_d      (ctrl_d),
    .i_alu_result_m(alu_result_m),
    .i_result_w    (result_w),
    .o_pc_f        (pc_f),
    .o_instr_d     (instr_d),
    .o_pc_d        (pc_d),
    .o_rs1_addr_d  (rs1_addr_d),
    .o_rs2_addr_d  (rs2_addr_d),
    .o_rs1_addr_e  (rs1_addr_e),
    .o_rs2_addr_e  (rs2_addr_e),
    .o_rd_addr_e   (rd_addr_e),
    .o_pc_e        (pc_e),
    .o_pc_plus4_e  (pc_plus4_e),
    .o_imm_e       (imm_e),
    .o_ctrl_e      (ctrl_e),
    .o_src_a_e     (src_a_e),
`ifdef PIPE_PERF_CNT_EN
    .o_stall_cnt   (stall_cnt),
    .o_flush_cnt   (flush_cnt),
`endif
    .o_write_data_e(write_data_e)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
    pc_src  = 1'b0; pc_target_e = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    clear_ctrl();
    forward_ae = 2'b00; forward_be = 2'b00;
    instr_f = 32'd0; rs1_data_d = 32'd0; rs2_data_d = 32'd0; imm_d = 32'd0; ctrl_d = 16'd0;
    alu_result_m = 32'd0; result_w = 32'd0;

    // Reset held two cycles, with junk on the inputs that reset must override.
    instr_f = INSTR_X; ctrl_d = 16'hFFFF; stall_f = 1'b1;
    tick();
    tick();
    check("rst_pc_f",    pc_f,             32'h100);
    check("rst_instr_d", instr_d,          32'h13);
    check("rst_pc_d",    pc_d,             32'h0);
    check("rst_ctrl_e",  {16'd0, ctrl_e},  32'h0);
    check("rst_pc4_e",   pc_plus4_e,       32'h0);
`ifdef PIPE_PERF_CNT_EN
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
`endif

    // Straight-line flow: A fetched at 0x100.
    rst = 1'b0; clear_ctrl(); ctrl_d = 16'h0000;
    instr_f = INSTR_A;
    tick();
    check("flow_pc_f_104", pc_f,    32'h104);
    check("flow_instr_d_A", instr_d, INSTR_A);
    check("flow_pc_d_A",   pc_d,    32'h100);
    check("flow_rs1_d_A",  {27'd0, rs1_addr_d}, 32'd6);
    check("flow_rs2_d_A",  {27'd0, rs2_addr_d}, 32'd7);

    // Decode of A supplies its operands; B fetched at 0x104.
    instr_f = INSTR_B; rs1_data_d = 32'h11; rs2_data_d = 32'h55; imm_d = 32'hDEAD_0001; ctrl_d = 16'hA5C3;
    tick();
    check("flow_pc_f_108",  pc_f,               32'h108);
    check("flow_instr_d_B", instr_d,            INSTR_B);
    check("flow_rd_e_A",    {27'd0, rd_addr_e}, 32'd5);
    check("flow_rs1_e_A",   {27'd0, rs1_addr_e}, 32'd6);
    check("flow_rs2_e_A",   {27'd0, rs2_addr_e}, 32'd7);
    check("flow_imm_e_A",   imm_e,              32'hDEAD_0001);
    check("flow_ctrl_e_A",  {16'd0, ctrl_e},    32'h0000_A5C3);
    check("flow_pc_e_A",    pc_e,               32'h100);
    check("flow_pc4_e_A",   pc_plus4_e,         32'h104);

    // Forwarding on A in EX: rs1=0x11, rs2=0x55, W=0x22, M=0x33.
    result_w = 32'h22; alu_result_m = 32'h33;
    forward_ae = 2'b00; forward_be = 2'b00; #1;
    check("fwd_a_00", src_a_e,      32'h11);
    check("fwd_b_00", write_data_e, 32'h55);
    forward_ae = 2'b01; forward_be = 2'b01; #1;
    check("fwd_a_01", src_a_e,      32'h22);
    check("fwd_b_01", write_data_e, 32'h22);
    forward_ae = 2'b10; forward_be = 2'b10; #1;
    check("fwd_a_10", src_a_e,      32'h33);
    check("fwd_b_10", write_data_e, 32'h33);
    forward_ae = 2'b11; forward_be = 2'b11; #1;
    check("fwd_a_11", src_a_e,      32'h11);
    check("fwd_b_11", write_data_e, 32'h55);
    forward_ae = 2'b10; forward_be = 2'b00; #1;
    check("fwd_mixed_a", src_a_e,      32'h33);
    check("fwd_mixed_b", write_data_e, 32'h55);
    forward_ae = 2'b00;

    // Load-use stall with B in decode and C at the fetch port.
    instr_f = INSTR_C; rs1_data_d = 32'h99; rs2_data_d = 32'h98; imm_d = 32'h0000_0B0B; ctrl_d = 16'h00B2;
    stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
    tick();
    check("lu_pc_f_hold",    pc_f,              32'h108);
    check("lu_instr_d_hold", instr_d,           INSTR_B);
    check("lu_pc_d_hold",    pc_d,              32'h104);
    check("lu_ctrl_e_bub",   {16'd0, ctrl_e},   32'h0);
    check("lu_rd_e_bub",     {27'd0, rd_addr_e}, 32'h0);
    check("lu_pc4_e_bub",    pc_plus4_e,        32'h0);
    check("lu_src_a_bub",    src_a_e,           32'h0);

    // Resume: B enters EX exactly once, C enters decode.
    clear_ctrl();
    tick();
    check("res_pc_f",     pc_f,               32'h10C);
    check("res_instr_d",  instr_d,            INSTR_C);
    check("res_pc_d",     pc_d,               32'h108);
    check("res_rd_e_B",   {27'd0, rd_addr_e}, 32'd8);
    check("res_rs1_e_B",  {27'd0, rs1_addr_e}, 32'd9);
    check("res_ctrl_e_B", {16'd0, ctrl_e},    32'h00B2);
    check("res_pc_e_B",   pc_e,               32'h104);
    check("res_imm_e_B",  imm_e,              32'h0000_0B0B);
    check("res_src_a_B",  src_a_e,            32'h99);

    // Branch redirect: target wins over stall_f, flush wins over stall_d.
    instr_f = INSTR_X; ctrl_d = 16'h7777;
    pc_src = 1'b1; pc_target_e = 32'h200;
    stall_f = 1'b1; stall_d = 1'b1; flush_d = 1'b1; flush_e = 1'b1;
    tick();
    check("br_pc_f",     pc_f,            32'h200);
    check("br_instr_d",  instr_d,         32'h13);
    check("br_pc_d",     pc_d,            32'h0);
    check("br_ctrl_e",   {16'd0, ctrl_e}, 32'h0);

    clear_ctrl();
    tick();
    check("post_br_pc_f",    pc_f,    32'h204);
    check("post_br_instr_d", instr_d, INSTR_X);
    check("post_br_pc_d",    pc_d,    32'h200);

    // PC wrap modulo 2^32.
    pc_src = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    tick();
    check("wrap_pc_f_top", pc_f, 32'hFFFF_FFFC);
    clear_ctrl();
    tick();
    check("wrap_pc_f_zero", pc_f, 32'h0);
    check("wrap_pc_d",      pc_d, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc4_e", pc_plus4_e, 32'h0);

    // Fresh reset, then 3 decode-only stall cycles and 2 execute-flush cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    instr_f = INSTR_A;
    stall_d = 1'b1;
    tick(); tick(); tick();
    check("sd_only_instr_d", instr_d, 32'h13);
    check("sd_only_pc_f",    pc_f,    32'h10C);
    stall_d = 1'b0; flush_e = 1'b1; ctrl_d = 16'h1234;
    tick(); tick();
    check("fe_only_ctrl_e",  {16'd0, ctrl_e}, 32'h0);
    check("fe_only_instr_d", instr_d,         INSTR_A);
    stall_f = 1'b1; flush_e = 1'b0;
    tick();
    check("sf_only_pc_hold", pc_f, 32'h114);
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall_cnt", stall_cnt, 32'd3);
    check("perf_flush_cnt", flush_cnt, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
